// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states and
// the byte-strobe helper used by the register write path.
package irq_pkg;

    localparam int MAX_SRC = 32;
    localparam int ID_W    = 5;

    localparam logic [31:0] REG_ENABLE  = 32'h0000_0000;
    localparam logic [31:0] REG_MODE    = 32'h0000_0004;
    localparam logic [31:0] REG_PENDING = 32'h0000_0008;
    localparam logic [31:0] REG_ACTIVE  = 32'h0000_000C;
    localparam logic [31:0] REG_SWTRIG  = 32'h0000_0010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } irq_state_e;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/AXI_LITE.sv
// AXI4-Lite bundle with 32-bit address and data, used for register access.
interface AXI_LITE;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: the lowest set index wins.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [ID_W-1:0]  id
);

    // Walk from the top down so the last hit is the lowest index.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronised sources, edge/level pending logic, a one-at-a-time
// IDLE/ACTIVE/GAP delivery FSM and an AXI4-Lite register block.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int N_SRC       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               resetn,
    AXI_LITE.slave             axi,
    input  logic [N_SRC-1:0]   src,
    output logic [MAX_SRC-1:0] irq,
    input  logic               eoi
);

    logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q, sync_d;
    logic [N_SRC-1:0] s;
    logic [N_SRC-1:0] s_prev_q, s_prev_d;
    logic [N_SRC-1:0] enable_q, enable_d;
    logic [N_SRC-1:0] mode_q, mode_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    irq_state_e       state_q, state_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             bvalid_q, bvalid_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             wr_en, rd_en;
    logic             wr_enable, wr_mode, wr_pending, wr_swtrig;
    logic [N_SRC-1:0] wr_keep, wr_data;
    logic [N_SRC-1:0] set_bits, clr_bits;
    logic             eoi_clear;
    logic             req_valid;
    logic [ID_W-1:0]  req_id;
    logic [31:0]      rd_word;

    assign s = sync_q[SYNC_STAGES-1];

    assign wr_en       = axi.awvalid & axi.wvalid & ~bvalid_q;
    assign rd_en       = axi.arvalid & ~rvalid_q;
    assign axi.awready = wr_en;
    assign axi.wready  = wr_en;
    assign axi.arready = rd_en;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = 2'b00;
    assign axi.rvalid  = rvalid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = 2'b00;

    assign wr_enable  = wr_en && (axi.awaddr == REG_ENABLE);
    assign wr_mode    = wr_en && (axi.awaddr == REG_MODE);
    assign wr_pending = wr_en && (axi.awaddr == REG_PENDING);
    assign wr_swtrig  = wr_en && (axi.awaddr == REG_SWTRIG);
    assign wr_keep    = N_SRC'(strb_mask(axi.wstrb));
    assign wr_data    = N_SRC'(axi.wdata & strb_mask(axi.wstrb));

    irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
        .req   (pending_q & enable_q),
        .valid (req_valid),
        .id    (req_id)
    );

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        eoi_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_ACTIVE;
                    id_d    = req_id;
                end
            end
            ST_ACTIVE: begin
                if (eoi) begin
                    state_d   = ST_GAP;
                    eoi_clear = 1'b1;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Edge-mode bits keep state and let a set win over a same-cycle clear; level bits track s.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], src};
        s_prev_d  = s;
        set_bits  = (s & ~s_prev_q) | (wr_swtrig ? wr_data : '0);
        clr_bits  = (wr_pending ? wr_data : '0) | (eoi_clear ? (N_SRC'(1) << id_q) : '0);
        pending_d = (mode_q & ((pending_q & ~clr_bits) | set_bits)) | (~mode_q & s);
        enable_d  = wr_enable ? ((enable_q & ~wr_keep) | wr_data) : enable_q;
        mode_d    = wr_mode ? ((mode_q & ~wr_keep) | wr_data) : mode_q;
    end

    always_comb begin
        case (axi.araddr)
            REG_ENABLE:  rd_word = 32'(enable_q);
            REG_MODE:    rd_word = 32'(mode_q);
            REG_PENDING: rd_word = 32'(pending_q);
            REG_ACTIVE:  rd_word = {state_q == ST_ACTIVE, 26'b0, id_q};
            default:     rd_word = 32'h0;
        endcase
        rdata_d  = rd_en ? rd_word : rdata_q;
        rvalid_d = rd_en ? 1'b1 : (axi.rready ? 1'b0 : rvalid_q);
        bvalid_d = wr_en ? 1'b1 : (axi.bready ? 1'b0 : bvalid_q);
    end

    assign irq = (state_q == ST_ACTIVE) ? (MAX_SRC'(1) << id_q) : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q    <= '0;
            s_prev_q  <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
            pending_q <= '0;
            state_q   <= ST_IDLE;
            id_q      <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            sync_q    <= sync_d;
            s_prev_q  <= s_prev_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            id_q      <= id_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule
